// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: restoring radix-2 iteration with
// start/busy/done handshake, IEEE special-case handling and four rounding modes.
module fp_div_seq #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MAN_W    = 23,
  parameter int unsigned BIAS     = 127,
  parameter int unsigned DIV_ITER = 26
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start_ext,
  input  logic             Sx_ext,
  input  logic             Sy_ext,
  input  logic [EXP_W-1:0] Ex_ext,
  input  logic [EXP_W-1:0] Ey_ext,
  input  logic [MAN_W-1:0] Mx_ext,
  input  logic [MAN_W-1:0] My_ext,
  input  logic [1:0]       R_mode_ext,
  output logic             Busy_ext,
  output logic             Done_ext,
  output logic             Sz_ext,
  output logic [EXP_W-1:0] Ez_ext,
  output logic [MAN_W-1:0] Mz_ext,
  output logic             invalid_flag_ext,
  output logic             overflow_flag_ext,
  output logic             underflow_flag_ext,
  output logic             inexact_flag_ext,
  output logic             zero_flag_ext,
  output logic             div_by_zero_flag_ext
);

  localparam int unsigned SIG_W   = MAN_W + 1;
  localparam int unsigned REM_W   = SIG_W + 1;
  localparam int unsigned EA_W    = EXP_W + 2;
  localparam int unsigned CNT_W   = $clog2(DIV_ITER);
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
  localparam logic signed [EA_W-1:0] EA_TOP = EA_W'(EXP_MAX);
  localparam logic [MAN_W-1:0] QNAN_M = {1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DIVIDE, S_ROUND, S_FINISH
  } state_t;

  state_t state, state_nx;

  logic             sx, sy, sz;
  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W-1:0] mx, my;
  logic [1:0]       rmode;

  logic [REM_W-1:0]     rem;
  logic [SIG_W-1:0]     dvsr;
  logic [DIV_ITER-1:0]  quo;
  logic [CNT_W-1:0]     cnt;
  logic signed [EA_W-1:0] ea;

  logic             res_s;
  logic [EXP_W-1:0] res_e;
  logic [MAN_W-1:0] res_m;
  logic [5:0]       res_f;  // {invalid, overflow, underflow, inexact, zero, div_by_zero}

  // Operand classification; exponent 0 covers zeros and flushed subnormals
  logic x_zero, y_zero, x_nan, y_nan, x_inf, y_inf;
  logic is_inv, is_dbz, is_inf_res, is_zero_res, special;

  always_comb begin
    x_zero      = (ex == '0);
    y_zero      = (ey == '0);
    x_nan       = (ex == '1) && (mx != '0);
    y_nan       = (ey == '1) && (my != '0);
    x_inf       = (ex == '1) && (mx == '0);
    y_inf       = (ey == '1) && (my == '0);
    is_inv      = x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf);
    is_dbz      = !is_inv && y_zero && !x_inf;
    is_inf_res  = !is_inv && x_inf;
    is_zero_res = !is_inv && !is_dbz && !is_inf_res && (x_zero || y_inf);
    special     = is_inv || is_dbz || is_inf_res || is_zero_res;
  end

  // Trial subtraction for one restoring step
  logic [REM_W:0] diff;
  assign diff = {1'b0, rem} - {2'b00, dvsr};

  // Normalisation and rounding of the finished quotient
  logic                   q_top, grd, stk, inc, carry, ovf, unf, to_inf;
  logic [DIV_ITER-1:0]    q_norm;
  logic signed [EA_W-1:0] e_norm, e_fin;
  logic [SIG_W-1:0]       sig;
  logic [SIG_W:0]         sig_r;
  logic [MAN_W-1:0]       man_r;

  always_comb begin
    q_top  = quo[DIV_ITER-1];
    q_norm = q_top ? quo : {quo[DIV_ITER-2:0], 1'b0};
    e_norm = q_top ? ea : ea - EA_W'(1);
    sig    = q_norm[DIV_ITER-1 -: SIG_W];
    grd    = q_norm[DIV_ITER-SIG_W-1];
    stk    = (|q_norm[DIV_ITER-SIG_W-2:0]) || (rem != '0);
    inc    = 1'b0;
    case (rmode)
      2'b00:   inc = grd && (sig[0] || stk);
      2'b01:   inc = 1'b0;
      2'b10:   inc = !sz && (grd || stk);
      default: inc = sz && (grd || stk);
    endcase
    sig_r  = {1'b0, sig} + (SIG_W+1)'(inc);
    carry  = sig_r[SIG_W];
    man_r  = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    e_fin  = e_norm + EA_W'(carry);
    ovf    = (e_fin >= EA_TOP);
    unf    = e_fin[EA_W-1] || (e_fin == '0);
    to_inf = (rmode == 2'b00) || (rmode == 2'b10 && !sz) || (rmode == 2'b11 && sz);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (Start_ext && !Busy_ext) state_nx = S_LOAD;
      S_LOAD:   state_nx = special ? S_FINISH : S_DIVIDE;
      S_DIVIDE: if (cnt == CNT_W'(DIV_ITER-1)) state_nx = S_ROUND;
      S_ROUND:  state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result staging
  always_ff @(posedge CLK) begin
    case (state)
      S_IDLE: if (Start_ext && !Busy_ext) begin
        sx <= Sx_ext;  sy <= Sy_ext;
        ex <= Ex_ext;  ey <= Ey_ext;
        mx <= Mx_ext;  my <= My_ext;
        rmode <= R_mode_ext;
      end
      S_LOAD: begin
        sz   <= sx ^ sy;
        rem  <= REM_W'({1'b1, mx});
        dvsr <= {1'b1, my};
        quo  <= '0;
        cnt  <= '0;
        ea   <= EA_W'(ex) - EA_W'(ey) + EA_W'(BIAS);
        res_s <= sx ^ sy;
        res_e <= '1;
        res_m <= '0;
        res_f <= 6'b000000;
        if (is_inv) begin
          res_s <= 1'b0;
          res_m <= QNAN_M;
          res_f <= 6'b100000;
        end else if (is_dbz) begin
          res_f <= 6'b000001;
        end else if (is_zero_res) begin
          res_e <= '0;
          res_f <= 6'b000010;
        end
      end
      S_DIVIDE: begin
        if (!diff[REM_W]) begin
          rem <= {diff[REM_W-2:0], 1'b0};
          quo <= {quo[DIV_ITER-2:0], 1'b1};
        end else begin
          rem <= {rem[REM_W-2:0], 1'b0};
          quo <= {quo[DIV_ITER-2:0], 1'b0};
        end
        cnt <= cnt + CNT_W'(1);
      end
      S_ROUND: begin
        res_s <= sz;
        if (ovf) begin
          res_f <= 6'b010100;
          res_e <= to_inf ? EXP_W'(EXP_MAX) : EXP_W'(EXP_MAX - 1);
          res_m <= to_inf ? '0 : '1;
        end else if (unf) begin
          res_f <= 6'b001110;
          res_e <= '0;
          res_m <= '0;
        end else begin
          res_f <= {3'b000, grd || stk, 2'b00};
          res_e <= e_fin[EXP_W-1:0];
          res_m <= man_r;
        end
      end
      default: ;
    endcase
  end

  // Registered handshake and result outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      Busy_ext             <= 1'b0;
      Done_ext             <= 1'b0;
      Sz_ext               <= 1'b0;
      Ez_ext               <= '0;
      Mz_ext               <= '0;
      invalid_flag_ext     <= 1'b0;
      overflow_flag_ext    <= 1'b0;
      underflow_flag_ext   <= 1'b0;
      inexact_flag_ext     <= 1'b0;
      zero_flag_ext        <= 1'b0;
      div_by_zero_flag_ext <= 1'b0;
    end else begin
      Busy_ext <= (state != S_IDLE) || (Start_ext && !Busy_ext);
      Done_ext <= (state == S_FINISH);
      if (state == S_FINISH) begin
        Sz_ext <= res_s;
        Ez_ext <= res_e;
        Mz_ext <= res_m;
        {invalid_flag_ext, overflow_flag_ext, underflow_flag_ext,
         inexact_flag_ext, zero_flag_ext, div_by_zero_flag_ext} <= res_f;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed divisions with hand-computed
// results, checked by an independent monitor on every Done_ext pulse.
module tb_fp_div_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start_ext = 1'b0;
  logic        Sx_ext = 1'b0, Sy_ext = 1'b0;
  logic [7:0]  Ex_ext = '0, Ey_ext = '0;
  logic [22:0] Mx_ext = '0, My_ext = '0;
  logic [1:0]  R_mode_ext = '0;
  logic        Busy_ext, Done_ext, Sz_ext;
  logic [7:0]  Ez_ext;
  logic [22:0] Mz_ext;
  logic        invalid_flag_ext, overflow_flag_ext, underflow_flag_ext;
  logic        inexact_flag_ext, zero_flag_ext, div_by_zero_flag_ext;

  fp_div_seq dut (
    .CLK(CLK), .RST(RST), .Start_ext(Start_ext),
    .Sx_ext(Sx_ext), .Sy_ext(Sy_ext), .Ex_ext(Ex_ext), .Ey_ext(Ey_ext),
    .Mx_ext(Mx_ext), .My_ext(My_ext), .R_mode_ext(R_mode_ext),
    .Busy_ext(Busy_ext), .Done_ext(Done_ext), .Sz_ext(Sz_ext),
    .Ez_ext(Ez_ext), .Mz_ext(Mz_ext),
    .invalid_flag_ext(invalid_flag_ext), .overflow_flag_ext(overflow_flag_ext),
    .underflow_flag_ext(underflow_flag_ext), .inexact_flag_ext(inexact_flag_ext),
    .zero_flag_ext(zero_flag_ext), .div_by_zero_flag_ext(div_by_zero_flag_ext)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  id;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [5:0]  f;   // {invalid, overflow, underflow, inexact, zero, div_by_zero}
    logic [7:0]  lat;
    logic [31:0] t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL op%0d %s: got %h expected %h (t=%0t)", id, nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input logic s, input logic [7:0] e,
                              input logic [22:0] m, input logic [5:0] f, input int lat);
    exp_t r;
    r.id  = 8'(id);
    r.s   = s;
    r.e   = e;
    r.m   = m;
    r.f   = f;
    r.lat = 8'(lat);
    r.t0  = '0;
    return r;
  endfunction

  // Monitor: every Done_ext pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (!RST && Done_ext) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 0, 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sign", int'(mon_e.id), 32'(Sz_ext), 32'(mon_e.s));
        chk("exp", int'(mon_e.id), 32'(Ez_ext), 32'(mon_e.e));
        chk("man", int'(mon_e.id), 32'(Mz_ext), 32'(mon_e.m));
        chk("flags", int'(mon_e.id),
            32'({invalid_flag_ext, overflow_flag_ext, underflow_flag_ext,
                 inexact_flag_ext, zero_flag_ext, div_by_zero_flag_ext}), 32'(mon_e.f));
        chk("latency", int'(mon_e.id), 32'(cyc) - mon_e.t0, 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                       input logic sy, input logic [7:0] ey, input logic [22:0] my,
                       input logic [1:0] rm, input logic push, input exp_t e);
    @(negedge CLK);
    Sx_ext = sx; Ex_ext = ex; Mx_ext = mx;
    Sy_ext = sy; Ey_ext = ey; My_ext = my;
    R_mode_ext = rm;
    Start_ext = 1'b1;
    @(posedge CLK);
    #1;
    Start_ext = 1'b0;
    if (push) begin
      e.t0 = 32'(cyc);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 0, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(posedge CLK);
  endtask

  task automatic op(input int id, input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                    input logic sy, input logic [7:0] ey, input logic [22:0] my,
                    input logic [1:0] rm, input logic s, input logic [7:0] e,
                    input logic [22:0] m, input logic [5:0] f, input int lat);
    issue(sx, ex, mx, sy, ey, my, rm, 1'b1, mk(id, s, e, m, f, lat));
    drain();
  endtask

  task automatic chk_idle_outputs(input int id);
    chk("busy", id, 32'(Busy_ext), 32'd0);
    chk("done", id, 32'(Done_ext), 32'd0);
    chk("sz", id, 32'(Sz_ext), 32'd0);
    chk("ez", id, 32'(Ez_ext), 32'd0);
    chk("mz", id, 32'(Mz_ext), 32'd0);
    chk("flags", id, 32'({invalid_flag_ext, overflow_flag_ext, underflow_flag_ext,
                          inexact_flag_ext, zero_flag_ext, div_by_zero_flag_ext}), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk_idle_outputs(0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    //  id  sx  ex     mx          sy  ey     my          rm     s   e      m          flags      lat
    op(1,  0, 8'd129, 23'h400000, 0, 8'd128, 23'h000000, 2'b00, 0, 8'd128, 23'h400000, 6'b000000, 29); // 6/2
    op(2,  0, 8'd127, 23'h000000, 0, 8'd128, 23'h400000, 2'b00, 0, 8'd125, 23'h2AAAAB, 6'b000100, 29); // 1/3 RNE
    op(3,  0, 8'd127, 23'h000000, 0, 8'd128, 23'h400000, 2'b01, 0, 8'd125, 23'h2AAAAA, 6'b000100, 29); // 1/3 RTZ
    op(4,  1, 8'd127, 23'h000000, 0, 8'd128, 23'h400000, 2'b10, 1, 8'd125, 23'h2AAAAA, 6'b000100, 29); // -1/3 +inf
    op(5,  1, 8'd127, 23'h000000, 0, 8'd128, 23'h400000, 2'b11, 1, 8'd125, 23'h2AAAAB, 6'b000100, 29); // -1/3 -inf
    op(6,  0, 8'd127, 23'h400000, 0, 8'd127, 23'h400000, 2'b00, 0, 8'd127, 23'h000000, 6'b000000, 29); // 1.5/1.5
    op(7,  0, 8'd127, 23'h000000, 0, 8'd0,   23'h000000, 2'b00, 0, 8'd255, 23'h000000, 6'b000001, 2);  // 1/0
    op(8,  0, 8'd0,   23'h000000, 1, 8'd0,   23'h000000, 2'b00, 0, 8'd255, 23'h400000, 6'b100000, 2);  // 0/-0
    op(9,  1, 8'd255, 23'h000000, 0, 8'd255, 23'h000000, 2'b00, 0, 8'd255, 23'h400000, 6'b100000, 2);  // -inf/inf
    op(10, 0, 8'd255, 23'h000001, 0, 8'd127, 23'h000000, 2'b00, 0, 8'd255, 23'h400000, 6'b100000, 2);  // NaN/1
    op(11, 0, 8'd255, 23'h000000, 1, 8'd128, 23'h000000, 2'b00, 1, 8'd255, 23'h000000, 6'b000000, 2);  // inf/-2
    op(12, 1, 8'd0,   23'h000000, 0, 8'd129, 23'h200000, 2'b00, 1, 8'd0,   23'h000000, 6'b000010, 2);  // -0/5
    op(13, 0, 8'd129, 23'h200000, 0, 8'd255, 23'h000000, 2'b00, 0, 8'd0,   23'h000000, 6'b000010, 2);  // 5/inf
    op(14, 0, 8'd0,   23'h000005, 0, 8'd127, 23'h000000, 2'b00, 0, 8'd0,   23'h000000, 6'b000010, 2);  // subnormal/1
    op(15, 0, 8'd254, 23'h000000, 0, 8'd1,   23'h000000, 2'b00, 0, 8'd255, 23'h000000, 6'b010100, 29); // ovf RNE
    op(16, 0, 8'd254, 23'h000000, 0, 8'd1,   23'h000000, 2'b01, 0, 8'd254, 23'h7FFFFF, 6'b010100, 29); // ovf RTZ
    op(17, 0, 8'd254, 23'h000000, 0, 8'd1,   23'h000000, 2'b11, 0, 8'd254, 23'h7FFFFF, 6'b010100, 29); // ovf -inf, pos
    op(18, 1, 8'd254, 23'h000000, 0, 8'd1,   23'h000000, 2'b11, 1, 8'd255, 23'h000000, 6'b010100, 29); // ovf -inf, neg
    op(19, 0, 8'd1,   23'h000000, 0, 8'd254, 23'h000000, 2'b00, 0, 8'd0,   23'h000000, 6'b001110, 29); // underflow
    op(20, 1, 8'd1,   23'h000000, 0, 8'd254, 23'h000000, 2'b00, 1, 8'd0,   23'h000000, 6'b001110, 29); // -underflow

    // A second start while busy must not disturb the captured 6/2 operands
    issue(0, 8'd129, 23'h400000, 0, 8'd128, 23'h000000, 2'b00, 1'b1,
          mk(21, 0, 8'd128, 23'h400000, 6'b000000, 29));
    repeat (4) @(posedge CLK);
    issue(1, 8'd127, 23'h000000, 0, 8'd128, 23'h400000, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drain();

    // Reset in the middle of an operation: outputs clear, no Done_ext follows
    issue(0, 8'd127, 23'h000000, 0, 8'd128, 23'h400000, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    repeat (4) @(posedge CLK);
    #1;
    chk("busy_mid_op", 22, 32'(Busy_ext), 32'd1);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk_idle_outputs(22);
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(posedge CLK);

    op(23, 0, 8'd129, 23'h400000, 0, 8'd128, 23'h000000, 2'b00, 0, 8'd128, 23'h400000, 6'b000000, 29);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Single-precision IEEE-754 divider (Z = X / Y), the inverse-operation companion to the FPU multiplier path.
- Takes the same unpacked sign/exponent/mantissa fields and 2-bit rounding mode, and returns the same field and flag set, plus divide-by-zero.
- Implemented as a multi-cycle restoring radix-2 iterator with a start/busy/done handshake.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width
BIAS, 127, exponent bias
DIV_ITER, 26, quotient bits generated (24 significand + guard + round)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
Start_ext  in  1  start pulse; operands sampled when Start_ext=1 and Busy_ext=0
Sx_ext, Sy_ext  in  1  operand signs
Ex_ext, Ey_ext  in  EXP_W  biased exponents
Mx_ext, My_ext  in  MAN_W  stored mantissas
R_mode_ext  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
Busy_ext  out  1  operation in progress
Done_ext  out  1  one-cycle pulse; result outputs valid
Sz_ext  out  1  result sign
Ez_ext  out  EXP_W  result exponent
Mz_ext  out  MAN_W  result mantissa
invalid_flag_ext, overflow_flag_ext, underflow_flag_ext, inexact_flag_ext, zero_flag_ext, div_by_zero_flag_ext  out  1 each  IEEE flags

Behaviour:
- Reset: one clock and a synchronous, active-high RST. When RST=1 at a CLK edge:
  - FSM goes to IDLE.
  - All outputs, including Busy_ext and Done_ext, become 0.
  - This applies mid-operation too: the in-flight result is discarded and Done_ext never pulses for it.
- FSM states: IDLE, LOAD, DIVIDE, ROUND, FINISH.
- IDLE: on Start_ext=1, register all operand fields and R_mode, then go to LOAD. Busy_ext=1 from the next cycle.
- Start_ext while Busy_ext=1 is ignored; captured operands are unchanged.
- LOAD:
  - Sz = Sx^Sy.
  - Exponent 0 means zero; subnormal inputs are flushed to signed zero.
  - Classify special cases, in priority order:
    1. NaN input, 0/0, or inf/inf: invalid=1; canonical qNaN: Sz=0, Ez=255, Mz=0x400000.
    2. Finite nonzero / 0: div_by_zero=1; Ez=255, Mz=0.
    3. inf / finite: Ez=255, Mz=0.
    4. 0 / nonzero, or finite / inf: Ez=0, Mz=0, zero=1.
  - Special case: go to FINISH.
  - Otherwise:
    - Dividend = {1,Mx}, divisor = {1,My}.
    - Exponent accumulator (signed, EXP_W+2 bits) = Ex - Ey + BIAS.
    - Iteration counter = 0; go to DIVIDE.
- DIVIDE:
  - Each cycle: trial subtract remainder - divisor. If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0. Then remainder <<= 1.
  - Exactly DIV_ITER cycles, then ROUND.
- ROUND:
  - If quotient MSB = 0 (ratio < 1): shift quotient left 1 and decrement exponent.
  - Guard = next bit below the 24-bit significand; sticky = remaining bits OR (remainder != 0).
  - Round by R_mode:
    - RNE: increment if G & (LSB | sticky).
    - RTZ: never increment.
    - +inf: increment if !Sz & (G | sticky).
    - -inf: increment if Sz & (G | sticky).
  - Mantissa carry-out: shift right 1, exponent +1.
  - inexact = G | sticky.
- Overflow (final exponent >= 255): overflow=1, inexact=1.
  - Result is inf (Ez=255, Mz=0) for RNE, and for the directed mode matching the sign.
  - Otherwise max finite (Ez=254, Mz=0x7FFFFF).
- Underflow (final exponent <= 0): underflow=1, inexact=1, zero=1; result is signed zero.
- FINISH: register the result and flags to the outputs, Done_ext=1 for one cycle, Busy_ext=0 in the following cycle, return to IDLE.
  - Outputs hold until the next FINISH or reset.
  - Flags are recomputed every operation; they are not sticky.
- Latency, counted from the Start-sampling edge to the cycle with Done_ext=1:
  - Normal path: 29 cycles.
  - Special path: 2 cycles.
  - Start_ext is accepted again in the cycle Done_ext=1? No; it is accepted from the first IDLE cycle after FINISH.

Test Plan:
- 6.0/2.0 (Ex=129, Mx=0x400000; Ey=128, My=0), RNE -> Sz=0, Ez=128, Mz=0x400000, all flags 0, Done_ext at cycle 29.
- 1.0/3.0 (Ex=127, Mx=0; Ey=128, My=0x400000):
  - RNE -> Ez=125, Mz=0x2AAAAB, inexact=1.
  - RTZ -> Mz=0x2AAAAA.
  - -1.0/3.0 in mode 10 -> Sz=1, Mz=0x2AAAAA.
- Specials:
  - 1.0/0 -> Ez=255, Mz=0, div_by_zero=1, Done_ext at cycle 2.
  - 0/0 -> invalid=1, Sz=0, Ez=255, Mz=0x400000.
  - inf/inf -> invalid=1.
- Overflow: Ex=254, Mx=0 / Ey=1, My=0:
  - RNE -> Ez=255, Mz=0, overflow=1, inexact=1.
  - RTZ -> Ez=254, Mz=0x7FFFFF.
- Underflow: Ex=1 / Ey=254 -> Ez=0, Mz=0, underflow=1, inexact=1, zero=1.
- Control:
  - RST=1 at cycle 10 of an operation -> Busy_ext=0 and outputs 0 next cycle; no Done_ext.
  - Start_ext pulsed at cycle 5 of another operation -> ignored; the original operands' result is returned at cycle 29.
